// File: rtl/writeback_stage.sv
// Register-file write side of the datapath: selects the result source, waits for
// load data when needed, formats it, and drives one registered write port.
module writeback_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [1:0]      ex_wb_sel,
  input  logic            ex_reg_write,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_utype_imm,
  input  logic [2:0]      ex_funct3,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            load_pending,
  output logic            err_stray_rsp
);

  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_WAIT_LOAD = 1'b1;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_IMM  = 2'b11;

  logic [0:0]      state_r;
  logic [4:0]      rd_r;
  logic            we_r;
  logic [2:0]      funct3_r;
  logic [1:0]      off_r;
  logic            accept_s;
  logic            we_q_s;
  logic [XLEN-1:0] nonload_data_s;
  logic [XLEN-1:0] load_data_s;

  // Align the selected byte/half of the returned word and extend it.
  function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'd0, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign ex_ready     = (state_r == ST_IDLE);
  assign load_pending = (state_r == ST_WAIT_LOAD);
  assign accept_s     = ex_valid && ex_ready;
  assign we_q_s       = ex_reg_write && (ex_rd != 5'd0);
  assign load_data_s  = format_load(funct3_r, off_r, dmem_rdata);

  // Result mux for instructions that retire without a memory response.
  always_comb begin
    nonload_data_s = ex_alu_result;
    case (ex_wb_sel)
      SEL_ALU: nonload_data_s = ex_alu_result;
      SEL_PC4: nonload_data_s = ex_pc + 32'd4;
      SEL_IMM: nonload_data_s = ex_utype_imm;
      default: nonload_data_s = ex_alu_result;
    endcase
  end

  // State, captured load context, stray-response flag and the write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      rd_r          <= 5'd0;
      we_r          <= 1'b0;
      funct3_r      <= 3'd0;
      off_r         <= 2'd0;
      rf_we         <= 1'b0;
      rf_waddr      <= 5'd0;
      rf_wdata      <= '0;
      err_stray_rsp <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (dmem_rvalid) begin
            err_stray_rsp <= 1'b1;
          end
          if (accept_s) begin
            if (ex_wb_sel == SEL_LOAD) begin
              state_r  <= ST_WAIT_LOAD;
              rd_r     <= ex_rd;
              we_r     <= we_q_s;
              funct3_r <= ex_funct3;
              off_r    <= ex_alu_result[1:0];
            end else begin
              rf_we <= we_q_s;
              if (we_q_s) begin
                rf_waddr <= ex_rd;
                rf_wdata <= nonload_data_s;
              end
            end
          end
        end
        ST_WAIT_LOAD: begin
          // No timeout: the load holds the stage until memory answers.
          if (dmem_rvalid) begin
            state_r <= ST_IDLE;
            rf_we   <= we_r;
            if (we_r) begin
              rf_waddr <= rd_r;
              rf_wdata <= load_data_s;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed vectors push expected writes,
// a negedge monitor pops and compares every rf_we pulse.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_wb_sel;
  logic        ex_reg_write;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_pc;
  logic [31:0] ex_utype_imm;
  logic [2:0]  ex_funct3;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_pending;
  logic        err_stray_rsp;

  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q[$];

  writeback_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wb_sel(ex_wb_sel),
    .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .ex_alu_result(ex_alu_result),
    .ex_pc(ex_pc), .ex_utype_imm(ex_utype_imm), .ex_funct3(ex_funct3),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .load_pending(load_pending), .err_stray_rsp(err_stray_rsp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%08h expected no write", rf_waddr, rf_wdata);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          errors++;
          $display("FAIL write: got addr=%0d data=0x%08h expected addr=%0d data=0x%08h",
                   rf_waddr, rf_wdata, e[36:32], e[31:0]);
        end
      end
    end
  end

  // Drive one instruction for exactly one accepting edge; returns #1 after that edge.
  task automatic issue(input logic [1:0] sel, input logic rw, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [2:0] f3);
    chk("ready_before_issue", {31'd0, ex_ready}, 32'd1);
    ex_wb_sel = sel; ex_reg_write = rw; ex_rd = rd; ex_alu_result = alu;
    ex_pc = pc; ex_utype_imm = imm; ex_funct3 = f3; ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic do_load(input logic [4:0] rd, input logic rw, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] rdata, input int delay,
                         input logic do_write, input logic [31:0] exp_data);
    if (do_write) exp_q.push_back({rd, exp_data});
    issue(2'b01, rw, rd, addr, 32'h0, 32'h0, f3);
    for (int i = 0; i < delay - 1; i++) begin
      chk("load_stall_ready", {31'd0, ex_ready}, 32'd0);
      chk("load_stall_pending", {31'd0, load_pending}, 32'd1);
      @(posedge clk); #1;
    end
    chk("load_stall_ready", {31'd0, ex_ready}, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chk("load_done_ready", {31'd0, ex_ready}, 32'd1);
    chk("load_done_pending", {31'd0, load_pending}, 32'd0);
    chk("load_done_we", {31'd0, rf_we}, {31'd0, do_write});
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_wb_sel = 2'b00; ex_reg_write = 1'b0; ex_rd = 5'd0;
    ex_alu_result = 32'h0; ex_pc = 32'h0; ex_utype_imm = 32'h0; ex_funct3 = 3'd0;
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("reset_ready", {31'd0, ex_ready}, 32'd1);
    chk("reset_we", {31'd0, rf_we}, 32'd0);
    chk("reset_pending", {31'd0, load_pending}, 32'd0);
    chk("reset_err", {31'd0, err_stray_rsp}, 32'd0);
    @(posedge clk); #1;

    // Write lands, then an async reset mid-cycle must wipe it before the monitor samples.
    issue(2'b00, 1'b1, 5'd9, 32'h000055AA, 32'h0, 32'h0, 3'd0);
    chk("pre_reset_we", {31'd0, rf_we}, 32'd1);
    chk("pre_reset_addr", {27'd0, rf_waddr}, 32'd9);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_we", {31'd0, rf_we}, 32'd0);
    chk("async_rst_addr", {27'd0, rf_waddr}, 32'd0);
    chk("async_rst_data", rf_wdata, 32'h0);
    chk("async_rst_pending", {31'd0, load_pending}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("release_ready", {31'd0, ex_ready}, 32'd1);
    @(posedge clk); #1;

    // ALU, pc+4 wrap, U-immediate back to back.
    exp_q.push_back({5'd5, 32'h00001234});
    issue(2'b00, 1'b1, 5'd5, 32'h00001234, 32'h0, 32'h0, 3'd0);
    chk("b2b_we_0", {31'd0, rf_we}, 32'd1);
    exp_q.push_back({5'd1, 32'h00000000});
    issue(2'b10, 1'b1, 5'd1, 32'h0, 32'hFFFFFFFC, 32'h0, 3'd0);
    chk("b2b_we_1", {31'd0, rf_we}, 32'd1);
    exp_q.push_back({5'd2, 32'hABCDE000});
    issue(2'b11, 1'b1, 5'd2, 32'h0, 32'h0, 32'hABCDE000, 3'd0);
    chk("b2b_we_2", {31'd0, rf_we}, 32'd1);

    // Loads: byte/half/word formatting, various latencies and offsets.
    do_load(5'd6,  1'b1, 32'h00001003, 3'b000, 32'h80FF7F01, 3, 1'b1, 32'hFFFFFF80);
    do_load(5'd7,  1'b1, 32'h00001000, 3'b100, 32'h80FF7F01, 1, 1'b1, 32'h00000001);
    do_load(5'd8,  1'b1, 32'h00001001, 3'b000, 32'h80FF7F01, 2, 1'b1, 32'h0000007F);
    do_load(5'd10, 1'b1, 32'h00001002, 3'b000, 32'h80FF7F01, 1, 1'b1, 32'hFFFFFFFF);
    do_load(5'd11, 1'b1, 32'h00002002, 3'b001, 32'h8001F00F, 1, 1'b1, 32'hFFFF8001);
    do_load(5'd12, 1'b1, 32'h00002003, 3'b001, 32'h8001F00F, 2, 1'b1, 32'hFFFF8001);
    do_load(5'd13, 1'b1, 32'h00002000, 3'b101, 32'h8001F00F, 1, 1'b1, 32'h0000F00F);
    do_load(5'd14, 1'b1, 32'h00002000, 3'b001, 32'h8001F00F, 1, 1'b1, 32'hFFFFF00F);
    do_load(5'd15, 1'b1, 32'h00002003, 3'b011, 32'h8001F00F, 1, 1'b1, 32'h8001F00F);
    do_load(5'd16, 1'b1, 32'h00002000, 3'b010, 32'h8001F00F, 1, 1'b1, 32'h8001F00F);

    // A new instruction accepted on the very edge the load's write appears.
    exp_q.push_back({5'd17, 32'h00000042});
    issue(2'b00, 1'b1, 5'd17, 32'h00000042, 32'h0, 32'h0, 3'd0);
    chk("after_load_we", {31'd0, rf_we}, 32'd1);

    // x0 and reg_write=0 guards; port must hold its last write.
    issue(2'b00, 1'b1, 5'd0, 32'hCAFEF00D, 32'h0, 32'h0, 3'd0);
    chk("x0_we", {31'd0, rf_we}, 32'd0);
    chk("hold_addr", {27'd0, rf_waddr}, 32'd17);
    chk("hold_data", rf_wdata, 32'h00000042);
    issue(2'b00, 1'b0, 5'd3, 32'h11111111, 32'h0, 32'h0, 3'd0);
    chk("nowrite_we", {31'd0, rf_we}, 32'd0);
    do_load(5'd0, 1'b1, 32'h00003000, 3'b010, 32'h12345678, 3, 1'b0, 32'h0);
    chk("x0_load_hold_data", rf_wdata, 32'h00000042);

    // Stray response in IDLE.
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chk("stray_err", {31'd0, err_stray_rsp}, 32'd1);
    chk("stray_we", {31'd0, rf_we}, 32'd0);
    @(posedge clk); #1;
    chk("stray_sticky", {31'd0, err_stray_rsp}, 32'd1);

    // Reset during WAIT_LOAD, then the late response counts as stray.
    issue(2'b01, 1'b1, 5'd20, 32'h00004000, 32'h0, 32'h0, 3'b010);
    chk("wait_pending", {31'd0, load_pending}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midload_rst_pending", {31'd0, load_pending}, 32'd0);
    chk("midload_rst_err", {31'd0, err_stray_rsp}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h99999999;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chk("late_rsp_err", {31'd0, err_stray_rsp}, 32'd1);
    chk("late_rsp_we", {31'd0, rf_we}, 32'd0);

    exp_q.push_back({5'd21, 32'h00000777});
    issue(2'b00, 1'b1, 5'd21, 32'h00000777, 32'h0, 32'h0, 3'd0);
    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Register-file write side of the core's datapath: the counterpart to operand selection, which reads `rs1`/`rs2` out of the register file. It accepts one retiring instruction per handshake from the execute stage and selects the result source (ALU, load data, `pc+4`, U-type immediate). For loads it waits for the data-memory response, then aligns and sign- or zero-extends the returned word. It drives a single registered register-file write port.

## Interface
Parameters:
- `XLEN`, default 32: data and address width. Only 32 is supported.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ex_valid`  in  1  execute stage presents an instruction.
- `ex_ready`  out  1  stage can accept; equals (state == IDLE).
- `ex_wb_sel`  in  2  result source: 00 ALU, 01 memory load, 10 `pc+4`, 11 U-type immediate.
- `ex_reg_write`  in  1  instruction writes `rd`.
- `ex_rd`  in  5  destination register.
- `ex_alu_result`  in  32  ALU result; for loads, this is the byte address.
- `ex_pc`  in  32  instruction PC.
- `ex_utype_imm`  in  32  U-type immediate, already shifted.
- `ex_funct3`  in  3  load size/sign code.
- `dmem_rvalid`  in  1  load data valid, 1-cycle pulse.
- `dmem_rdata`  in  32  load data word, aligned.
- `rf_we`  out  1  register-file write enable, registered.
- `rf_waddr`  out  5  write address, registered.
- `rf_wdata`  out  32  write data, registered.
- `load_pending`  out  1  high while in WAIT_LOAD.
- `err_stray_rsp`  out  1  sticky flag: `dmem_rvalid` arrived while in IDLE.

## Operation
- **Accept:** an instruction is accepted when `ex_valid && ex_ready`. On accept, the stage captures `rd`, `reg_write`, `funct3` and `alu_result[1:0]`.
- **Write qualifier:** `we_q = ex_reg_write && (ex_rd != 0)`. Writes to x0 are never issued.
- **Non-load (`wb_sel != 01`), state stays IDLE:**
  - `rf_wdata` is `alu_result`, `pc + 32'd4`, or `utype_imm` per `wb_sel`.
  - `pc+4` wraps modulo 2^32.
- **Load (`wb_sel == 01`):**
  - State goes IDLE -> WAIT_LOAD, and `ex_ready` drops.
  - In WAIT_LOAD, on `dmem_rvalid` the stage formats `dmem_rdata` using the captured `funct3` and offset, then returns to IDLE.
- **Load formatting:**
  - 000 LB: byte at `[8*off+7 : 8*off]`, sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: half at `off[1]` (low half if 0, high half if 1), sign-extended; `off[0]` is ignored.
  - 101 LHU: same half, zero-extended.
  - 010 LW, and the undefined codes 011/110/111: full word; the offset is ignored.
- **Write port:**
  - `rf_we` is a single-cycle pulse carrying `we_q`.
  - `rf_waddr` and `rf_wdata` hold their last written values when `rf_we` is 0.
- **States:**
  - IDLE -> WAIT_LOAD on accepting a load.
  - WAIT_LOAD -> IDLE on `dmem_rvalid`.
  - No other transitions.
- **Stray response:** `dmem_rvalid` while in IDLE is ignored for data and sets `err_stray_rsp`. Only `rst` clears the flag.
- A load with `reg_write=0` or `rd=0` still waits for `dmem_rvalid`, but writes nothing.

## Timing
- **Reset values:** state IDLE, `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `load_pending=0`, `err_stray_rsp=0`. `ex_ready=1` one delta after reset is released.
- **Non-load latency:** accepted on edge N -> `rf_we` high during cycle N+1. Back-to-back non-loads give a write every cycle.
- **Load latency:**
  - Accepted on edge N -> `load_pending`=1 and `ex_ready`=0 from cycle N+1.
  - `dmem_rvalid` sampled high on edge M -> `rf_we` high in cycle M+1, with `load_pending`=0 and `ex_ready`=1 in M+1.
  - Earliest M is N+1, so the minimum load occupancy is 2 cycles. There is no timeout.
- A new instruction can be accepted on the same edge that the load's write becomes visible (M+1).
- **Reset mid-load:** the pending load is discarded and no write is issued. An `rvalid` that arrives after reset counts as stray and sets `err_stray_rsp`.
- `ex_ready` is combinational from state only. It has no combinational path from `ex_valid` or `dmem_rvalid`.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle -> all outputs 0 immediately, `ex_ready=1` after release.
- **ALU / pc+4 / imm back-to-back, no stalls:**
  - Stimulus, in order: `wb_sel`=00 with `alu_result`=0x1234 and rd=5; `wb_sel`=10 with pc=0xFFFFFFFC and rd=1; `wb_sel`=11 with imm=0xABCDE000 and rd=2.
  - Required: three consecutive `rf_we` pulses with data 0x1234, 0x00000000 (wrap), 0xABCDE000.
- **LB:** `dmem_rdata`=0x80FF7F01, `alu_result`=...3, rdata returned 3 cycles after accept -> `ex_ready` low for 3 cycles, then one write of 0xFFFFFF80.
  - Same word, LBU at offset 0 -> 0x00000001.
- **LH/LHU:** `dmem_rdata`=0x8001F00F:
  - LH at offset 2 -> 0xFFFF8001.
  - LHU at offset 0 -> 0x0000F00F.
  - LW -> 0x8001F00F.
- **x0 guard:** ALU write with rd=0 and `reg_write`=1 -> `rf_we` stays 0. The same case as a load -> the stage still stalls until `rvalid`, with no write.
- **Errors/reset:**
  - `dmem_rvalid` pulse in IDLE -> `err_stray_rsp`=1 and no write.
  - `rst` during WAIT_LOAD, then `rvalid` -> no write, `err_stray_rsp`=1.
